// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch and load/store requesters.
// Optional ARB_ROUND_ROBIN_EN: alternate winners on collision instead of data priority.
module mem_port_arbiter #(
    parameter int BITNESS  = 32,
    parameter int TIMEOUT  = 15,
    parameter int BE_WIDTH = BITNESS / 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                if_req_i,
    input  logic [BITNESS-1:0]  if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [BITNESS-1:0]  if_rdata_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [BITNESS-1:0]  d_addr_i,
    input  logic [BITNESS-1:0]  d_wdata_i,
    input  logic [BE_WIDTH-1:0] d_be_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [BITNESS-1:0]  d_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [BITNESS-1:0]  mem_addr_o,
    output logic [BITNESS-1:0]  mem_wdata_o,
    output logic [BE_WIDTH-1:0] mem_be_o,
    input  logic                mem_rvalid_i,
    input  logic [BITNESS-1:0]  mem_rdata_i,
    output logic                stall_o,
    output logic                err_o
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic       OWN_FETCH   = 1'b0;
    localparam logic       OWN_DATA    = 1'b1;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic       owner_q;
    logic [7:0] cnt_q;
    logic       winner;
    logic       grant;
    logic       resp;
    logic       abort;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_winner_q;

    always_comb begin
        winner = (if_req_i & d_req_i) ? ~last_winner_q : d_req_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_winner_q <= OWN_FETCH;
        end else if (grant) begin
            last_winner_q <= winner;
        end
    end
`else
    always_comb begin
        winner = d_req_i;
    end
`endif

    // NOTE: every output and next-state value gets a default before any branch, so no latches are inferred.
    always_comb begin
        state_d     = state_q;
        if_gnt_o    = 1'b0;
        d_gnt_o     = 1'b0;
        if_rvalid_o = 1'b0;
        d_rvalid_o  = 1'b0;
        if_rdata_o  = '0;
        d_rdata_o   = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        err_o       = 1'b0;

        // Reset holds state at IDLE; masking with rst_i keeps grants quiet while it is held.
        grant = ~rst_i & (state_q == IDLE) & (if_req_i | d_req_i);
        resp  = (state_q == WAIT) & mem_rvalid_i;
        abort = (state_q == WAIT) & ~mem_rvalid_i & (cnt_q == TIMEOUT_CNT);

        if (grant) begin
            state_d   = WAIT;
            mem_req_o = 1'b1;
            if (winner == OWN_DATA) begin
                d_gnt_o     = 1'b1;
                mem_we_o    = d_we_i;
                mem_addr_o  = d_addr_i;
                mem_wdata_o = d_wdata_i;
                mem_be_o    = d_be_i;
            end else begin
                if_gnt_o   = 1'b1;
                mem_addr_o = if_addr_i;
            end
        end

        if (resp || abort) begin
            state_d = IDLE;
            err_o   = abort;
            if (owner_q == OWN_DATA) begin
                d_rvalid_o = 1'b1;
                d_rdata_o  = resp ? mem_rdata_i : '0;
            end else begin
                if_rvalid_o = 1'b1;
                if_rdata_o  = resp ? mem_rdata_i : '0;
            end
        end

        stall_o = ~rst_i & ((if_req_i & ~if_gnt_o) | (d_req_i & ~d_gnt_o) |
                            ((state_q == WAIT) & ~mem_rvalid_i));
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= OWN_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q <= winner;
                cnt_q   <= '0;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: cycle vector table plus scoreboarded
// multi-cycle sequences (timeout, late response, collisions, reset mid-transaction).
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 15;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i, d_req_i, d_we_i, mem_rvalid_i;
    logic [31:0] if_addr_i, d_addr_i, d_wdata_i, mem_rdata_i;
    logic [3:0]  d_be_i;
    logic        if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o;
    logic        mem_req_o, mem_we_o, stall_o, err_o;
    logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;

    mem_port_arbiter #(.BITNESS(32), .TIMEOUT(TIMEOUT), .BE_WIDTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_be_i(d_be_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        ir; logic [31:0] ia;
        logic        dr; logic dw; logic [31:0] da; logic [31:0] dd; logic [3:0] db;
        logic        mv; logic [31:0] md;
    } in_t;

    typedef struct packed {
        logic        ig; logic iv; logic [31:0] ird;
        logic        dg; logic dv; logic [31:0] drd;
        logic        mr; logic mw; logic [31:0] ma; logic [31:0] mwd; logic [3:0] mb;
        logic        st; logic er;
    } out_t;

    typedef struct packed { in_t i; out_t o; } vec_t;

    typedef struct {
        logic        port;      // 0 = fetch, 1 = data
        logic [31:0] rdata;
        logic        err;
        logic        chk_data;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic in_t iv(logic ir, logic [31:0] ia, logic dr, logic dw, logic [31:0] da,
                               logic [31:0] dd, logic [3:0] db, logic mv, logic [31:0] md);
        return {ir, ia, dr, dw, da, dd, db, mv, md};
    endfunction

    function automatic out_t ov(logic ig, logic ivl, logic [31:0] ird, logic dg, logic dv,
                                logic [31:0] drd, logic mr, logic mw, logic [31:0] ma,
                                logic [31:0] mwd, logic [3:0] mb, logic st, logic er);
        return {ig, ivl, ird, dg, dv, drd, mr, mw, ma, mwd, mb, st, er};
    endfunction

    function automatic out_t sample();
        return {if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
                mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, stall_o, err_o};
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        if_req_i = v.ir; if_addr_i = v.ia;
        d_req_i = v.dr; d_we_i = v.dw; d_addr_i = v.da; d_wdata_i = v.dd; d_be_i = v.db;
        mem_rvalid_i = v.mv; mem_rdata_i = v.md;
    endtask

    task automatic do_reset();
        drive('0);
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // Pops the oldest expected response and compares it to the response on the ports now.
    task automatic pop_check(input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({name, "_unexpected"}, 160'(1), 160'(0));
            return;
        end
        e = exp_q.pop_front();
        check({name, "_port"}, 160'({if_rvalid_o, d_rvalid_o}), 160'(e.port ? 2'b01 : 2'b10));
        check({name, "_err"}, 160'(err_o), 160'(e.err));
        if (e.port) begin
            check({name, "_if_rdata"}, 160'(if_rdata_o), 160'(0));
            if (e.chk_data) check({name, "_d_rdata"}, 160'(d_rdata_o), 160'(e.rdata));
        end else begin
            check({name, "_d_rdata"}, 160'(d_rdata_o), 160'(0));
            check({name, "_if_rdata"}, 160'(if_rdata_o), 160'(e.rdata));
        end
    endtask

    task automatic issue(input string name, input logic port, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        @(negedge clk_i);
        drive('0);
        if (port) begin
            d_req_i = 1'b1; d_we_i = we; d_addr_i = addr; d_wdata_i = wdata; d_be_i = be;
        end else begin
            if_req_i = 1'b1; if_addr_i = addr;
        end
        #1;
        check({name, "_gnt"}, 160'({if_gnt_o, d_gnt_o}), 160'(port ? 2'b01 : 2'b10));
        check({name, "_mem"}, 160'({mem_req_o, mem_we_o, mem_addr_o, mem_be_o}),
              160'({1'b1, we & port, addr, port ? be : 4'h0}));
    endtask

    // Memory answers on WAIT cycle 'delay' (never if delay <= 0); returns the observed latency.
    task automatic wait_resp(input string name, input int delay, input logic [31:0] rdata,
                             output int lat);
        lat = 0;
        for (int c = 1; c <= 3 * TIMEOUT; c++) begin
            @(negedge clk_i);
            drive('0);
            mem_rvalid_i = (c == delay);
            mem_rdata_i  = (c == delay) ? rdata : 32'h0;
            #1;
            if (if_rvalid_o || d_rvalid_o) begin
                pop_check(name);
                lat = c;
                break;
            end
        end
        if (lat == 0) check({name, "_resp_seen"}, 160'(0), 160'(1));
    endtask

    initial begin
        int   lat;
        logic exp_w[4];

        // cycle table: in = ir,ia,dr,dw,da,dd,db,mv,md ; out = ig,iv,ird,dg,dv,drd,mr,mw,ma,mwd,mb,st,er
        vecs.push_back({iv('0,32'h0,'0,'0,32'h0,32'h0,4'h0,'0,32'h0), ov('0,'0,32'h0,'0,'0,32'h0,'0,'0,32'h0,32'h0,4'h0,'0,'0)});
        vecs.push_back({iv('1,32'h10,'0,'0,32'h0,32'h0,4'h0,'0,32'h0), ov('1,'0,32'h0,'0,'0,32'h0,'1,'0,32'h10,32'h0,4'h0,'0,'0)});
        vecs.push_back({iv('0,32'h0,'0,'0,32'h0,32'h0,4'h0,'0,32'h0), ov('0,'0,32'h0,'0,'0,32'h0,'0,'0,32'h0,32'h0,4'h0,'1,'0)});
        vecs.push_back({iv('0,32'h0,'0,'0,32'h0,32'h0,4'h0,'0,32'h0), ov('0,'0,32'h0,'0,'0,32'h0,'0,'0,32'h0,32'h0,4'h0,'1,'0)});
        vecs.push_back({iv('0,32'h0,'0,'0,32'h0,32'h0,4'h0,'1,32'h00500093), ov('0,'1,32'h00500093,'0,'0,32'h0,'0,'0,32'h0,32'h0,4'h0,'0,'0)});
        vecs.push_back({iv('0,32'h0,'0,'0,32'h0,32'h0,4'h0,'1,32'hFFFFFFFF), ov('0,'0,32'h0,'0,'0,32'h0,'0,'0,32'h0,32'h0,4'h0,'0,'0)});
        vecs.push_back({iv('1,32'h20,'1,'0,32'h100,32'h0,4'h0,'0,32'h0), ov('0,'0,32'h0,'1,'0,32'h0,'1,'0,32'h100,32'h0,4'h0,'1,'0)});
        vecs.push_back({iv('1,32'h20,'0,'0,32'h0,32'h0,4'h0,'0,32'h0), ov('0,'0,32'h0,'0,'0,32'h0,'0,'0,32'h0,32'h0,4'h0,'1,'0)});
        vecs.push_back({iv('1,32'h20,'0,'0,32'h0,32'h0,4'h0,'1,32'hCAFEF00D), ov('0,'0,32'h0,'0,'1,32'hCAFEF00D,'0,'0,32'h0,32'h0,4'h0,'1,'0)});
        vecs.push_back({iv('1,32'h20,'0,'0,32'h0,32'h0,4'h0,'0,32'h0), ov('1,'0,32'h0,'0,'0,32'h0,'1,'0,32'h20,32'h0,4'h0,'0,'0)});
        vecs.push_back({iv('0,32'h0,'0,'0,32'h0,32'h0,4'h0,'1,32'h13), ov('0,'1,32'h13,'0,'0,32'h0,'0,'0,32'h0,32'h0,4'h0,'0,'0)});
        vecs.push_back({iv('0,32'h0,'1,'1,32'h104,32'hDEADBEEF,4'h3,'0,32'h0), ov('0,'0,32'h0,'1,'0,32'h0,'1,'1,32'h104,32'hDEADBEEF,4'h3,'0,'0)});
        vecs.push_back({iv('0,32'h0,'0,'0,32'h0,32'h0,4'h0,'1,32'h0), ov('0,'0,32'h0,'0,'1,32'h0,'0,'0,32'h0,32'h0,4'h0,'0,'0)});
        vecs.push_back({iv('0,32'h0,'1,'0,32'h200,32'h0,4'h0,'0,32'h0), ov('0,'0,32'h0,'1,'0,32'h0,'1,'0,32'h200,32'h0,4'h0,'0,'0)});
        vecs.push_back({iv('1,32'h30,'0,'0,32'h0,32'h0,4'h0,'0,32'h0), ov('0,'0,32'h0,'0,'0,32'h0,'0,'0,32'h0,32'h0,4'h0,'1,'0)});
        vecs.push_back({iv('0,32'h0,'0,'0,32'h0,32'h0,4'h0,'0,32'h0), ov('0,'0,32'h0,'0,'0,32'h0,'0,'0,32'h0,32'h0,4'h0,'1,'0)});
        vecs.push_back({iv('0,32'h0,'0,'0,32'h0,32'h0,4'h0,'1,32'h55), ov('0,'0,32'h0,'0,'1,32'h55,'0,'0,32'h0,32'h0,4'h0,'0,'0)});
        vecs.push_back({iv('0,32'h0,'0,'0,32'h0,32'h0,4'h0,'0,32'h0), ov('0,'0,32'h0,'0,'0,32'h0,'0,'0,32'h0,32'h0,4'h0,'0,'0)});

        // Reset holds every output low even with requests and a response present.
        rst_i = 1'b1;
        drive(iv('1,32'h10,'1,'1,32'h8,32'h1,4'hF,'1,32'h99));
        #1;
        check("reset_outputs", 160'(sample()), 160'(0));
        do_reset();

        foreach (vecs[k]) begin
            @(negedge clk_i);
            drive(vecs[k].i);
            #1;
            check($sformatf("vec%0d", k), 160'(sample()), 160'(vecs[k].o));
        end

        // Timeout: fetch never answered, abort after TIMEOUT+1 WAIT cycles.
        issue("to_fetch", 1'b0, 1'b0, 32'h40, 32'h0, 4'h0);
        exp_q.push_back('{port: 1'b0, rdata: 32'h0, err: 1'b1, chk_data: 1'b1});
        wait_resp("to_resp", 0, 32'h0, lat);
        check("to_latency", 160'(lat), 160'(TIMEOUT + 1));
        @(negedge clk_i);
        drive(iv('0,32'h0,'0,'0,32'h0,32'h0,4'h0,'1,32'h1234));
        #1;
        check("late_rvalid_ignored", 160'(sample()), 160'(0));

        // Response arriving exactly on the timeout cycle wins over the abort.
        issue("edge_fetch", 1'b0, 1'b0, 32'h44, 32'h0, 4'h0);
        exp_q.push_back('{port: 1'b0, rdata: 32'h0000ABCD, err: 1'b0, chk_data: 1'b1});
        wait_resp("edge_resp", TIMEOUT + 1, 32'h0000ABCD, lat);
        check("edge_latency", 160'(lat), 160'(TIMEOUT + 1));

        // Four simultaneous collision rounds from a fresh reset.
`ifdef ARB_ROUND_ROBIN_EN
        exp_w = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_w = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        do_reset();
        for (int r = 0; r < 4; r++) begin
            @(negedge clk_i);
            drive(iv('1,32'h20 + 32'(r),'1,'0,32'h100 + 32'(r),32'h0,4'h0,'0,32'h0));
            #1;
            check($sformatf("coll%0d_gnt", r), 160'({if_gnt_o, d_gnt_o}),
                  160'(exp_w[r] ? 2'b01 : 2'b10));
            check($sformatf("coll%0d_addr", r), 160'(mem_addr_o),
                  160'(exp_w[r] ? 32'h100 + 32'(r) : 32'h20 + 32'(r)));
            exp_q.push_back('{port: exp_w[r], rdata: 32'hA0 + 32'(r), err: 1'b0, chk_data: 1'b1});
            wait_resp($sformatf("coll%0d_resp", r), 1, 32'hA0 + 32'(r), lat);
        end

        // Reset two cycles into a load: dropped silently, next load completes.
        issue("rst_load", 1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
        @(negedge clk_i);
        drive('0);
        @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        drive(iv('0,32'h0,'1,'0,32'h300,32'h0,4'h0,'1,32'h77));
        #1;
        check("rst_mid_wait", 160'(sample()), 160'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(iv('0,32'h0,'0,'0,32'h0,32'h0,4'h0,'1,32'h77));
        #1;
        check("rst_late_rvalid", 160'(sample()), 160'(0));
        issue("post_rst_load", 1'b1, 1'b0, 32'h304, 32'h0, 4'h0);
        exp_q.push_back('{port: 1'b1, rdata: 32'h88, err: 1'b0, chk_data: 1'b1});
        wait_resp("post_rst_resp", 2, 32'h88, lat);
        check("post_rst_latency", 160'(lat), 160'(2));
        check("scoreboard_empty", 160'(exp_q.size()), 160'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
